axis_mm_ring_ctrl: RTL and testbench
====================================

Name: axis_mm_ring_ctrl

Overview:
- Sequencer that drives the AXI-stream→AXI-MM write bridge into a host-memory circular buffer (ring).
- Per frame descriptor: checks ring space against the host read pointer, issues the start address to the bridge, and gates the bridge's stream input.
- Counts bridge B responses to detect frame completion, then commits the write pointer.
- Sits between the frame descriptor source (MAC/app logic) and the bridge's axi_base_addr / B-channel interface.

Parameters:
- ADDR_WIDTH, 34, AXI address width.
- PTR_WIDTH, 32, width of the free-running byte pointers.
- LEN_WIDTH, 16, frame length width in bytes.
- BEAT_BYTES, 64, bytes per bridge transaction; power of two.
- MAX_LOG2, 24, maximum allowed cfg_ring_log2.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- cfg_enable  in  1  run enable; sampled only in IDLE
- cfg_base_addr  in  ADDR_WIDTH  ring base address; BEAT_BYTES aligned
- cfg_ring_log2  in  5  ring size = 2^cfg_ring_log2 bytes; legal range log2(BEAT_BYTES)..MAX_LOG2
- host_rd_ptr  in  PTR_WIDTH  free-running host consumer byte pointer
- s_desc_len  in  LEN_WIDTH  frame length in bytes; must be ≥1
- s_desc_valid  in  1  descriptor valid
- s_desc_ready  out  1  descriptor accept
- axi_base_addr  out  ADDR_WIDTH  frame start address to the bridge
- axi_base_addr_valid  out  1  one-cycle address strobe
- stream_en  out  1  gates bridge s_axis_tvalid/tready
- m_axi_bvalid  in  1  snooped bridge B valid
- m_axi_bready  in  1  snooped bridge B ready
- m_axi_bresp  in  2  snooped B response
- wr_ptr  out  PTR_WIDTH  committed free-running producer byte pointer
- ring_full  out  1  high while stalled for space
- busy  out  1  state ≠ IDLE
- err  out  1  sticky error flag

Behaviour:
- Reset values (async on rst_n low): all outputs 0, wr_ptr=0, state IDLE. Release is synchronous to clk.
- Derived quantities:
  - beats = ceil(len/BEAT_BYTES).
  - alen = beats*BEAT_BYTES.
  - off = wr_ptr & (2^log2−1).
  - pad = (off+alen > 2^log2) ? 2^log2−off : 0.
  - need = pad+alen.
  - occ = wr_ptr − host_rd_ptr, modulo 2^PTR_WIDTH.
  - space = 2^log2 − occ.
- FSM:
  - IDLE: s_desc_ready=cfg_enable. On valid&ready, latch len → CALC.
  - CALC (1 cycle, registered arithmetic): compute need and space. If alen > 2^log2, set err and return to IDLE, discarding the descriptor. Else go to CHECK.
  - CHECK: if need ≤ space → ISSUE. Else ring_full=1 and stay; space is re-evaluated every cycle from the live host_rd_ptr.
  - ISSUE: axi_base_addr = cfg_base_addr + (pad ? 0 : off). axi_base_addr_valid=1 for exactly one cycle. stream_en←1. Beat counter ← beats. Go to WAIT.
  - WAIT: each bvalid&bready decrements the counter. On the final decrement, stream_en←0 in the same edge, wr_ptr ← wr_ptr+need, go to IDLE.
- Latency: descriptor accept to axi_base_addr_valid is 3 cycles when space is available.
- Boundaries:
  - off+alen == ring size exactly: no pad.
  - occ == ring size: space=0, so stall.
  - Pointer wrap at 2^PTR_WIDTH is handled by modular subtraction.
  - host_rd_ptr ahead of wr_ptr is illegal; space is treated as 0 and err is set.
  - B handshake in the same cycle as ISSUE is ignored; the bridge cannot respond before the address strobe.
  - cfg_enable deassert mid-frame does not abort; it takes effect in IDLE.
  - rst_n assert mid-frame: immediate return to reset values, with no commit.
- err clears only on rst_n or on a cfg_enable 0→1 edge.

Optional Feature:
- Macro: AXIS_MM_RING_BRESP_CHECK_EN.
- Defined: in WAIT, any handshake with m_axi_bresp ≠ 0 sets err, still counts toward completion, and the frame commits. The FSM then holds in IDLE with s_desc_ready=0 until err clears.
- Undefined: bresp is ignored and the m_axi_bresp port remains but is unused.

Decomposition:
- Shared package axis_mm_pkg holds:
  - state encoding localparams (IDLE, CALC, CHECK, ISSUE, WAIT);
  - the BRESP OKAY constant;
  - the ceil-to-beat helper function.
- One sub-module: axis_mm_ring_space. It is the registered need/space calculator (off, pad, need, space, fits) and is reusable by a future read-side controller.

Test Plan:
- ring_log2=12, base 0x1_0000_0000, rd_ptr=0, len=100 → addr 0x1_0000_0000, 2 B handshakes, then wr_ptr=128, strobe 3 cycles after accept.
- wr_ptr=4032, rd_ptr=4000, len=128 → pad 64, addr=base+0, wr_ptr=4224 after 2 Bs.
- occ=4096 (wr=4096, rd=0), len=64 → ring_full held. Step rd_ptr to 64 → issue the next cycle after CHECK sees space.
- len=5000 with log2=12 → err=1, descriptor dropped, wr_ptr unchanged. Toggling cfg_enable clears err.
- Pull rst_n low during WAIT after 1 of 3 Bs → all outputs 0 asynchronously, wr_ptr=0.
- With AXIS_MM_RING_BRESP_CHECK_EN: second B with bresp=2'b10 → err=1, frame commits, s_desc_ready stays 0.

Source files
------------

// File: rtl/axis_mm_pkg.sv
// Shared state encoding, response constants and beat helper for the AXI-stream to AXI-MM ring controllers.
package axis_mm_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    CALC  = 3'd1,
    CHECK = 3'd2,
    ISSUE = 3'd3,
    WAIT  = 3'd4
  } ring_state_e;

  localparam logic [1:0] BRESP_OKAY = 2'b00;

  // Number of whole bridge beats needed to carry len_bytes, rounding up.
  function automatic logic [31:0] ceil_beats(input logic [31:0] len_bytes,
                                             input int unsigned beat_log2);
    logic [31:0] round_up;
    round_up = (32'd1 << beat_log2) - 32'd1;
    return (len_bytes + round_up) >> beat_log2;
  endfunction

endpackage

// File: rtl/axis_mm_ring_space.sv
// Registered ring-space calculator: frame offset, wrap pad, bytes needed and free space
// against a free-running consumer pointer. Usable by both write- and read-side controllers.
module axis_mm_ring_space
  import axis_mm_pkg::*;
#(
  parameter int          PTR_WIDTH  = 32,
  parameter int          LEN_WIDTH  = 16,
  parameter int unsigned BEAT_BYTES = 64,
  parameter int          MAX_LOG2   = 24
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [LEN_WIDTH-1:0] len_i,
  input  logic [PTR_WIDTH-1:0] wr_ptr_i,
  input  logic [PTR_WIDTH-1:0] rd_ptr_i,
  input  logic [4:0]           ring_log2_i,
  output logic [LEN_WIDTH-1:0] beats_o,
  output logic                 oversize_o,
  output logic [PTR_WIDTH-1:0] off_o,
  output logic                 pad_o,
  output logic [PTR_WIDTH:0]   need_o,
  output logic [PTR_WIDTH:0]   space_o,
  output logic                 fits_o,
  output logic                 illegal_o
);

  localparam int unsigned BEAT_LOG2 = $clog2(BEAT_BYTES);
  localparam int W = PTR_WIDTH + 1;

  logic [4:0]           log2_eff;
  logic [W-1:0]         ring, mask, off, alen, pad, need, occ, space;
  logic                 illegal;
  logic [PTR_WIDTH-1:0] off_q;
  logic                 pad_q, fits_q, illegal_q;
  logic [W-1:0]         need_q, space_q;

  // Out-of-range ring sizes are clamped so the arithmetic stays bounded.
  always_comb begin
    log2_eff = ring_log2_i;
    if (ring_log2_i > 5'(MAX_LOG2)) log2_eff = 5'(MAX_LOG2);
    if (ring_log2_i < 5'(BEAT_LOG2)) log2_eff = 5'(BEAT_LOG2);
    ring    = W'(1) << log2_eff;
    mask    = ring - W'(1);
    beats_o = LEN_WIDTH'(ceil_beats(32'(len_i), BEAT_LOG2));
    alen    = W'(beats_o) << BEAT_LOG2;
    off     = W'(wr_ptr_i) & mask;
    pad     = ((off + alen) > ring) ? (ring - off) : '0;
    need    = pad + alen;
    occ     = W'(wr_ptr_i - rd_ptr_i);
    illegal = occ > ring;
    space   = illegal ? '0 : (ring - occ);
    oversize_o = alen > ring;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      off_q     <= '0;
      pad_q     <= 1'b0;
      need_q    <= '0;
      space_q   <= '0;
      fits_q    <= 1'b0;
      illegal_q <= 1'b0;
    end else begin
      off_q     <= PTR_WIDTH'(off);
      pad_q     <= (pad != '0);
      need_q    <= need;
      space_q   <= space;
      fits_q    <= (need <= space);
      illegal_q <= illegal;
    end
  end

  assign off_o     = off_q;
  assign pad_o     = pad_q;
  assign need_o    = need_q;
  assign space_o   = space_q;
  assign fits_o    = fits_q;
  assign illegal_o = illegal_q;

endmodule

// File: rtl/axis_mm_ring_ctrl.sv
// Per-frame sequencer for the stream-to-memory bridge writing into a host ring buffer.
// Optional AXIS_MM_RING_BRESP_CHECK_EN flags non-OKAY B responses and blocks new frames until err clears.
module axis_mm_ring_ctrl
  import axis_mm_pkg::*;
#(
  parameter int          ADDR_WIDTH = 34,
  parameter int          PTR_WIDTH  = 32,
  parameter int          LEN_WIDTH  = 16,
  parameter int unsigned BEAT_BYTES = 64,
  parameter int          MAX_LOG2   = 24
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  cfg_enable,
  input  logic [ADDR_WIDTH-1:0] cfg_base_addr,
  input  logic [4:0]            cfg_ring_log2,
  input  logic [PTR_WIDTH-1:0]  host_rd_ptr,
  input  logic [LEN_WIDTH-1:0]  s_desc_len,
  input  logic                  s_desc_valid,
  output logic                  s_desc_ready,
  output logic [ADDR_WIDTH-1:0] axi_base_addr,
  output logic                  axi_base_addr_valid,
  output logic                  stream_en,
  input  logic                  m_axi_bvalid,
  input  logic                  m_axi_bready,
  input  logic [1:0]            m_axi_bresp,
  output logic [PTR_WIDTH-1:0]  wr_ptr,
  output logic                  ring_full,
  output logic                  busy,
  output logic                  err
);

  ring_state_e          state_q, state_d;
  logic [LEN_WIDTH-1:0] len_q, len_d;
  logic [LEN_WIDTH-1:0] beat_cnt_q, beat_cnt_d;
  logic [PTR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
  logic                 stream_en_q, stream_en_d;
  logic                 err_q, err_d;
  logic                 enable_q;

  logic [LEN_WIDTH-1:0] beats;
  logic                 oversize, pad_nz, fits, illegal;
  logic [PTR_WIDTH-1:0] off;
  logic [PTR_WIDTH:0]   need;
  logic [PTR_WIDTH:0]   ring_space_unused;
  logic                 b_hs;

  axis_mm_ring_space #(
    .PTR_WIDTH  (PTR_WIDTH),
    .LEN_WIDTH  (LEN_WIDTH),
    .BEAT_BYTES (BEAT_BYTES),
    .MAX_LOG2   (MAX_LOG2)
  ) u_space (
    .clk         (clk),
    .rst_n       (rst_n),
    .len_i       (len_q),
    .wr_ptr_i    (wr_ptr_q),
    .rd_ptr_i    (host_rd_ptr),
    .ring_log2_i (cfg_ring_log2),
    .beats_o     (beats),
    .oversize_o  (oversize),
    .off_o       (off),
    .pad_o       (pad_nz),
    .need_o      (need),
    .space_o     (ring_space_unused),
    .fits_o      (fits),
    .illegal_o   (illegal)
  );

  assign b_hs = m_axi_bvalid & m_axi_bready;

`ifndef AXIS_MM_RING_BRESP_CHECK_EN
  logic [1:0] bresp_unused;
  assign bresp_unused = m_axi_bresp;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      len_q       <= '0;
      beat_cnt_q  <= '0;
      wr_ptr_q    <= '0;
      stream_en_q <= 1'b0;
      err_q       <= 1'b0;
      enable_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      len_q       <= len_d;
      beat_cnt_q  <= beat_cnt_d;
      wr_ptr_q    <= wr_ptr_d;
      stream_en_q <= stream_en_d;
      err_q       <= err_d;
      enable_q    <= cfg_enable;
    end
  end

  // enable_q doubles as the enable edge detector and keeps ready low straight out of reset.
  always_comb begin
    state_d             = state_q;
    len_d               = len_q;
    beat_cnt_d          = beat_cnt_q;
    wr_ptr_d            = wr_ptr_q;
    stream_en_d         = stream_en_q;
    err_d               = err_q;
    s_desc_ready        = 1'b0;
    axi_base_addr       = '0;
    axi_base_addr_valid = 1'b0;
    ring_full           = 1'b0;
    if (cfg_enable && !enable_q) err_d = 1'b0;

    unique case (state_q)
      IDLE: begin
`ifdef AXIS_MM_RING_BRESP_CHECK_EN
        s_desc_ready = cfg_enable & enable_q & ~err_q;
`else
        s_desc_ready = cfg_enable & enable_q;
`endif
        if (s_desc_valid && s_desc_ready) begin
          len_d   = s_desc_len;
          state_d = CALC;
        end
      end
      CALC: begin
        if (oversize) begin
          err_d   = 1'b1;
          state_d = IDLE;
        end else begin
          state_d = CHECK;
        end
      end
      CHECK: begin
        if (illegal) err_d = 1'b1;
        if (fits) state_d = ISSUE;
        else      ring_full = 1'b1;
      end
      ISSUE: begin
        axi_base_addr       = cfg_base_addr + (pad_nz ? '0 : ADDR_WIDTH'(off));
        axi_base_addr_valid = 1'b1;
        stream_en_d         = 1'b1;
        beat_cnt_d          = beats;
        state_d             = WAIT;
      end
      WAIT: begin
        if (b_hs) begin
`ifdef AXIS_MM_RING_BRESP_CHECK_EN
          if (m_axi_bresp != BRESP_OKAY) err_d = 1'b1;
`endif
          beat_cnt_d = beat_cnt_q - 1'b1;
          if (beat_cnt_q <= LEN_WIDTH'(1)) begin
            stream_en_d = 1'b0;
            wr_ptr_d    = wr_ptr_q + PTR_WIDTH'(need);
            state_d     = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign busy      = (state_q != IDLE);
  assign stream_en = stream_en_q;
  assign wr_ptr    = wr_ptr_q;
  assign err       = err_q;

endmodule

// File: tb/tb_axis_mm_ring_ctrl.sv
// Directed scoreboard bench for axis_mm_ring_ctrl; the bresp-check scenario runs when
// AXIS_MM_RING_BRESP_CHECK_EN is defined, otherwise bresp is checked to be ignored.
`timescale 1ns/1ps
module tb_axis_mm_ring_ctrl;

  localparam logic [33:0] BASE = 34'h1_0000_0000;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cfg_enable;
  logic [33:0] cfg_base_addr;
  logic [4:0]  cfg_ring_log2;
  logic [31:0] host_rd_ptr;
  logic [15:0] s_desc_len;
  logic        s_desc_valid;
  logic        s_desc_ready;
  logic [33:0] axi_base_addr;
  logic        axi_base_addr_valid;
  logic        stream_en;
  logic        m_axi_bvalid;
  logic        m_axi_bready;
  logic [1:0]  m_axi_bresp;
  logic [31:0] wr_ptr;
  logic        ring_full;
  logic        busy;
  logic        err;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int acceptCyc = 0;
  int strobeCyc = 0;
  logic [31:0] expWr = 32'd0;
  logic [33:0] expQ[$];

  axis_mm_ring_ctrl dut (
    .clk                 (clk),
    .rst_n               (rst_n),
    .cfg_enable          (cfg_enable),
    .cfg_base_addr       (cfg_base_addr),
    .cfg_ring_log2       (cfg_ring_log2),
    .host_rd_ptr         (host_rd_ptr),
    .s_desc_len          (s_desc_len),
    .s_desc_valid        (s_desc_valid),
    .s_desc_ready        (s_desc_ready),
    .axi_base_addr       (axi_base_addr),
    .axi_base_addr_valid (axi_base_addr_valid),
    .stream_en           (stream_en),
    .m_axi_bvalid        (m_axi_bvalid),
    .m_axi_bready        (m_axi_bready),
    .m_axi_bresp         (m_axi_bresp),
    .wr_ptr              (wr_ptr),
    .ring_full           (ring_full),
    .busy                (busy),
    .err                 (err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic checkOutput(input string tag, input logic [127:0] observed,
                             input logic [127:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  function automatic logic [127:0] allOutputs();
    return 128'({s_desc_ready, axi_base_addr, axi_base_addr_valid, stream_en,
                 wr_ptr, ring_full, busy, err});
  endfunction

  // Every address strobe must match the oldest address queued when its descriptor was driven.
  always @(negedge clk) begin
    if (rst_n && axi_base_addr_valid) begin
      checkOutput("sb_has_entry", 128'(expQ.size() != 0), 128'(1));
      if (expQ.size() != 0)
        checkOutput("axi_base_addr", 128'(axi_base_addr), 128'(expQ.pop_front()));
    end
  end

  task automatic applyStimulus(input logic [15:0] len, input logic [31:0] rd);
    bit got = 1'b0;
    @(posedge clk); #1;
    host_rd_ptr  = rd;
    s_desc_len   = len;
    s_desc_valid = 1'b1;
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge clk);
      if (s_desc_ready) begin
        got = 1'b1;
        acceptCyc = cyc;
      end
    end
    checkOutput("desc_accept", 128'(got), 128'(1));
    @(posedge clk); #1;
    s_desc_valid = 1'b0;
  endtask

  task automatic waitStrobe(input string tag);
    bit seen = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(negedge clk);
      if (axi_base_addr_valid) begin
        seen = 1'b1;
        strobeCyc = cyc;
      end
    end
    checkOutput(tag, 128'(seen), 128'(1));
  endtask

  task automatic sendB(input int n, input logic [1:0] resp);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      m_axi_bvalid = 1'b1;
      m_axi_bready = 1'b1;
      m_axi_bresp  = resp;
      @(posedge clk); #1;
      m_axi_bvalid = 1'b0;
      m_axi_bresp  = 2'b00;
    end
  endtask

  task automatic waitIdle(input string tag);
    bit idle = 1'b0;
    for (int i = 0; i < 20 && !idle; i++) begin
      @(negedge clk);
      if (!busy) idle = 1'b1;
    end
    checkOutput(tag, 128'(idle), 128'(1));
  endtask

  task automatic toggleEnable();
    @(posedge clk); #1;
    cfg_enable = 1'b0;
    @(posedge clk); #1;
    cfg_enable = 1'b1;
    @(negedge clk);
    @(negedge clk);
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst_n = 1'b0; cfg_enable = 1'b0; cfg_base_addr = BASE; cfg_ring_log2 = 5'd12;
    host_rd_ptr = '0; s_desc_len = '0; s_desc_valid = 1'b0;
    m_axi_bvalid = 1'b0; m_axi_bready = 1'b0; m_axi_bresp = 2'b00;
    #2;
    checkOutput("reset_outputs", allOutputs(), 128'(0));
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    cfg_enable = 1'b1;

    $display("[TB] basic frame: len 100 at empty ring");
    expQ.push_back(BASE);
    applyStimulus(16'd100, 32'd0);
    waitStrobe("t1_strobe");
    checkOutput("t1_latency", 128'(strobeCyc - acceptCyc), 128'(3));
    @(negedge clk);
    checkOutput("t1_stream_en", 128'(stream_en), 128'(1));
    sendB(2, 2'b00);
    waitIdle("t1_idle");
    expWr = 32'd128;
    checkOutput("t1_wr_ptr", 128'(wr_ptr), 128'(expWr));
    checkOutput("t1_stream_off", 128'(stream_en), 128'(0));

    $display("[TB] fill to offset 4032");
    expQ.push_back(BASE + 34'd128);
    applyStimulus(16'd3904, 32'd128);
    waitStrobe("t1b_strobe");
    sendB(61, 2'b00);
    waitIdle("t1b_idle");
    expWr = 32'd4032;
    checkOutput("t1b_wr_ptr", 128'(wr_ptr), 128'(expWr));

    $display("[TB] wrap pad: len 128 at offset 4032, B during ISSUE ignored");
    expQ.push_back(BASE);
    applyStimulus(16'd128, 32'd4000);
    waitStrobe("t2_strobe");
    m_axi_bvalid = 1'b1;
    m_axi_bready = 1'b1;
    @(posedge clk); #1;
    m_axi_bvalid = 1'b0;
    sendB(1, 2'b00);
    @(negedge clk);
    checkOutput("t2_issue_b_ignored", 128'(busy), 128'(1));
    sendB(1, 2'b00);
    waitIdle("t2_idle");
    expWr = 32'd4224;
    checkOutput("t2_wr_ptr", 128'(wr_ptr), 128'(expWr));

    $display("[TB] exact fit to ring end without pad");
    expQ.push_back(BASE + 34'd128);
    applyStimulus(16'd3968, 32'd4224);
    waitStrobe("t3_strobe");
    sendB(62, 2'b00);
    waitIdle("t3_idle");
    expWr = 32'd8192;
    checkOutput("t3_wr_ptr", 128'(wr_ptr), 128'(expWr));

    $display("[TB] full ring stalls until host consumes");
    expQ.push_back(BASE);
    applyStimulus(16'd64, 32'd4096);
    repeat (6) @(negedge clk);
    checkOutput("t3b_ring_full", 128'(ring_full), 128'(1));
    checkOutput("t3b_busy_stalled", 128'(busy), 128'(1));
    @(posedge clk); #1;
    host_rd_ptr = 32'd4160;
    waitStrobe("t3b_issue_after_space");
    checkOutput("t3b_ring_full_clear", 128'(ring_full), 128'(0));
    sendB(1, 2'b00);
    waitIdle("t3b_idle");
    expWr = 32'd8256;
    checkOutput("t3b_wr_ptr", 128'(wr_ptr), 128'(expWr));

    $display("[TB] oversize frame dropped");
    applyStimulus(16'd5000, expWr);
    waitIdle("t4_idle");
    checkOutput("t4_err", 128'(err), 128'(1));
    checkOutput("t4_wr_ptr", 128'(wr_ptr), 128'(expWr));
    toggleEnable();
    checkOutput("t4_err_cleared", 128'(err), 128'(0));

`ifndef AXIS_MM_RING_BRESP_CHECK_EN
    $display("[TB] error bresp ignored in default build");
    expQ.push_back(BASE + 34'(expWr & 32'hFFF));
    applyStimulus(16'd64, expWr);
    waitStrobe("bresp_ign_strobe");
    sendB(1, 2'b10);
    waitIdle("bresp_ign_idle");
    expWr = expWr + 32'd64;
    checkOutput("bresp_ignored_err", 128'(err), 128'(0));
    checkOutput("bresp_ignored_wr", 128'(wr_ptr), 128'(expWr));
`endif

    $display("[TB] host pointer ahead of producer");
    expQ.push_back(BASE + 34'(expWr & 32'hFFF));
    applyStimulus(16'd64, expWr + 32'd64);
    repeat (4) @(negedge clk);
    checkOutput("illegal_err", 128'(err), 128'(1));
    checkOutput("illegal_ring_full", 128'(ring_full), 128'(1));
    @(posedge clk); #1;
    host_rd_ptr = expWr;
    waitStrobe("illegal_recover_strobe");
    sendB(1, 2'b00);
    waitIdle("illegal_idle");
    expWr = expWr + 32'd64;
    checkOutput("illegal_wr_ptr", 128'(wr_ptr), 128'(expWr));
    toggleEnable();
    checkOutput("illegal_err_cleared", 128'(err), 128'(0));

    $display("[TB] reset during WAIT after 1 of 3 responses");
    expQ.push_back(BASE + 34'(expWr & 32'hFFF));
    applyStimulus(16'd192, expWr);
    waitStrobe("t5_strobe");
    sendB(1, 2'b00);
    @(negedge clk);
    checkOutput("t5_busy_mid", 128'(busy), 128'(1));
    checkOutput("t5_stream_mid", 128'(stream_en), 128'(1));
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("t5_async_reset", allOutputs(), 128'(0));
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    expWr = 32'd0;

`ifdef AXIS_MM_RING_BRESP_CHECK_EN
    $display("[TB] error bresp flags err and blocks descriptors");
    expQ.push_back(BASE);
    applyStimulus(16'd100, 32'd0);
    waitStrobe("bresp_strobe");
    sendB(1, 2'b00);
    sendB(1, 2'b10);
    waitIdle("bresp_idle");
    checkOutput("bresp_err", 128'(err), 128'(1));
    checkOutput("bresp_wr_ptr", 128'(wr_ptr), 128'(128));
    repeat (3) @(negedge clk);
    checkOutput("bresp_ready_blocked", 128'(s_desc_ready), 128'(0));
`endif

    checkOutput("sb_drained", 128'(expQ.size()), 128'(0));
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
